// File: rtl/mem_access_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_stage_pkg
//  Purpose  : Shared constants for the MEM pipeline stage: default data / PC /
//             address widths, watchdog counter width and FSM state encodings.
//  Contents : c_DSIZE, c_ISIZE, c_AW, c_MAX_WAIT, c_CNT_W,
//             c_ST_IDLE / c_ST_BUSY, is_mem_op()
//  Revision : 1.0  initial release
// ============================================================================
package mem_access_stage_pkg;

    localparam int c_DSIZE    = 16;   // register file / memory word width
    localparam int c_ISIZE    = 16;   // PC width
    localparam int c_AW       = 8;    // data-memory word-address width
    localparam int c_MAX_WAIT = 15;   // BUSY cycles without ack before abort
    localparam int c_CNT_W    = 8;    // wide enough for MAX_WAIT up to 255

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_BUSY = 1'b1;

    // A load and a store together still count as one memory operation; the
    // store direction takes priority where the direction is decided.
    function automatic logic is_mem_op(input logic mem_read, input logic mem_write);
        return mem_read | mem_write;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_stage_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module   : mem_wait_timer
//  Purpose  : Counts BUSY cycles that pass without a memory acknowledge and
//             flags when the current cycle is the last one allowed.
//  Ports    : clk, rst      clock / synchronous active-high reset
//             i_clear       force the count to zero (held while idle)
//             i_enable      advance the count by one this cycle
//             o_expired     count has reached MAX_WAIT-1
//  Revision : 1.0  initial release
// ============================================================================
module mem_wait_timer
    import mem_access_stage_pkg::*;
#(
    parameter int MAX_WAIT = c_MAX_WAIT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    logic [c_CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Expiry is reported during the final permitted cycle so the owner can
    // abort on the same edge that would otherwise start cycle MAX_WAIT+1.
    assign o_expired = (r_count == c_CNT_W'(MAX_WAIT - 1));

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_stage
//  Purpose  : MEM pipeline stage. Takes the EX/MEM register outputs, performs
//             data-memory loads/stores over a req/ack bus, selects write-back
//             data (ALU result, load data or jal link PC) and registers it as
//             the MEM/WB pipeline register. A two-state FSM stalls upstream
//             while an access is outstanding; a watchdog aborts accesses that
//             are never acknowledged and sets a sticky error flag.
//  Ports    : clk, rst                 clock / sync active-high reset
//             w_addr_in, w_data_in     destination reg, ALU result (addr)
//             Rdata2_in                store data
//             memWrite_in, memRead_in  store / load request
//             memToReg_in, wen_in      WB select load data, RF write enable
//             jal_in, PC_in            WB select link PC
//             mem_req/we/addr/wdata    memory request bus (outputs)
//             mem_rdata, mem_ack       memory response
//             stall                    hold EX/MEM contents stable
//             wb_addr/wb_data/wb_wen   MEM/WB register
//             mem_err                  sticky access timeout flag
//  Revision : 1.0  initial release
// ============================================================================
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DSIZE    = c_DSIZE,
    parameter int ISIZE    = c_ISIZE,
    parameter int AW       = c_AW,
    parameter int MAX_WAIT = c_MAX_WAIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       w_addr_in,
    input  logic [DSIZE-1:0] w_data_in,
    input  logic [DSIZE-1:0] Rdata2_in,
    input  logic             memWrite_in,
    input  logic             memRead_in,
    input  logic             memToReg_in,
    input  logic             wen_in,
    input  logic             jal_in,
    input  logic [ISIZE-1:0] PC_in,
    output logic             mem_req,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [DSIZE-1:0] mem_wdata,
    input  logic [DSIZE-1:0] mem_rdata,
    input  logic             mem_ack,
    output logic             stall,
    output logic [3:0]       wb_addr,
    output logic [DSIZE-1:0] wb_data,
    output logic             wb_wen,
    output logic             mem_err
);

    logic [0:0]       r_state;

    // Fields captured when a memory op is accepted; upstream is free to change
    // its outputs only after the stall drops, but latching keeps the access
    // self-contained.
    logic             r_mem_req;
    logic             r_we;
    logic [DSIZE-1:0] r_alu;
    logic [DSIZE-1:0] r_wdata;
    logic [3:0]       r_dest;
    logic             r_wen;
    logic             r_m2r;
    logic             r_jal;
    logic [DSIZE-1:0] r_pc;

    logic [3:0]       r_wb_addr;
    logic [DSIZE-1:0] r_wb_data;
    logic             r_wb_wen;
    logic             r_mem_err;

    logic             w_mem_op;
    logic             w_idle;
    logic             w_busy;
    logic             w_expired;
    logic [DSIZE-1:0] w_pc_ext;
    logic [DSIZE-1:0] w_busy_wb_data;

    // Link PC is zero-extended or truncated to the data width.
    generate
        if (ISIZE >= DSIZE) begin : g_pc_trunc
            assign w_pc_ext = PC_in[DSIZE-1:0];
        end else begin : g_pc_ext
            assign w_pc_ext = {{(DSIZE-ISIZE){1'b0}}, PC_in};
        end
    endgenerate

    assign w_mem_op = is_mem_op(memRead_in, memWrite_in);
    assign w_idle   = (r_state == c_ST_IDLE);
    assign w_busy   = (r_state == c_ST_BUSY);

    // The cycle that completes or aborts an access releases upstream, so the
    // instruction moves on exactly on the edge that retires it.
    assign stall = (w_idle && w_mem_op) || (w_busy && !mem_ack && !w_expired);

    // Jal is checked first so a link write-back can never be overridden.
    assign w_busy_wb_data = r_jal ? r_pc : (r_m2r ? mem_rdata : r_alu);

    mem_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_idle),
        .i_enable  (w_busy && !mem_ack),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_mem_req <= 1'b0;
            r_we      <= 1'b0;
            r_alu     <= '0;
            r_wdata   <= '0;
            r_dest    <= '0;
            r_wen     <= 1'b0;
            r_m2r     <= 1'b0;
            r_jal     <= 1'b0;
            r_pc      <= '0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
            r_wb_wen  <= 1'b0;
            r_mem_err <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_mem_op) begin
                        r_state   <= c_ST_BUSY;
                        r_mem_req <= 1'b1;
                        r_we      <= memWrite_in;
                        r_alu     <= w_data_in;
                        r_wdata   <= Rdata2_in;
                        r_dest    <= w_addr_in;
                        r_wen     <= wen_in;
                        r_m2r     <= memToReg_in;
                        r_jal     <= jal_in;
                        r_pc      <= w_pc_ext;
                        r_wb_wen  <= 1'b0;   // bubble while the access runs
                    end else begin
                        r_wb_addr <= w_addr_in;
                        r_wb_data <= jal_in ? w_pc_ext : w_data_in;
                        r_wb_wen  <= wen_in;
                    end
                end
                c_ST_BUSY: begin
                    if (mem_ack) begin
                        // Ack beats a coincident timeout.
                        r_state   <= c_ST_IDLE;
                        r_mem_req <= 1'b0;
                        r_wb_addr <= r_dest;
                        r_wb_data <= w_busy_wb_data;
                        r_wb_wen  <= r_wen & ~r_we;   // stores never write back
                    end else if (w_expired) begin
                        r_state   <= c_ST_IDLE;
                        r_mem_req <= 1'b0;
                        r_mem_err <= 1'b1;
                        r_wb_wen  <= 1'b0;
                    end else begin
                        r_wb_wen  <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= c_ST_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_we;
    assign mem_addr  = r_alu[AW-1:0];
    assign mem_wdata = r_wdata;
    assign wb_addr   = r_wb_addr;
    assign wb_data   = r_wb_data;
    assign wb_wen    = r_wb_wen;
    assign mem_err   = r_mem_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_stage
//  Purpose  : Self-checking bench for mem_access_stage. A driver issues
//             instructions (directed, then random) and pushes expected
//             write-backs and memory transactions into queues; a memory
//             responder and a write-back monitor pop and compare.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_access_stage;

    localparam int DSIZE    = 16;
    localparam int ISIZE    = 16;
    localparam int AW       = 8;
    localparam int MAX_WAIT = 15;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       w_addr_in;
    logic [DSIZE-1:0] w_data_in;
    logic [DSIZE-1:0] Rdata2_in;
    logic             memWrite_in, memRead_in, memToReg_in, wen_in, jal_in;
    logic [ISIZE-1:0] PC_in;
    logic             mem_req, mem_we;
    logic [AW-1:0]    mem_addr;
    logic [DSIZE-1:0] mem_wdata;
    logic [DSIZE-1:0] mem_rdata;
    logic             mem_ack;
    logic             stall;
    logic [3:0]       wb_addr;
    logic [DSIZE-1:0] wb_data;
    logic             wb_wen;
    logic             mem_err;

    mem_access_stage #(
        .DSIZE(DSIZE), .ISIZE(ISIZE), .AW(AW), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk), .rst(rst),
        .w_addr_in(w_addr_in), .w_data_in(w_data_in), .Rdata2_in(Rdata2_in),
        .memWrite_in(memWrite_in), .memRead_in(memRead_in),
        .memToReg_in(memToReg_in), .wen_in(wen_in), .jal_in(jal_in), .PC_in(PC_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall(stall), .wb_addr(wb_addr), .wb_data(wb_data), .wb_wen(wb_wen),
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          noack;
        int          n;
        logic [15:0] rdata;
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
    } resp_t;

    typedef struct {
        logic [3:0]  a;
        logic [15:0] d;
    } wb_t;

    resp_t resp_q[$];
    wb_t   wb_q[$];
    int    checks = 0;
    int    errors = 0;
    bit    exp_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called just after a rising edge; returns just after the edge that
    // retires the instruction.
    task automatic issue(input logic rd, input logic wr, input logic m2r, input logic wen,
                         input logic jal, input logic [3:0] wa, input logic [15:0] wd,
                         input logic [15:0] rd2, input logic [15:0] pc,
                         input int n, input bit noack, input logic [15:0] rdata);
        bit    memop;
        int    exp_stall;
        int    cnt;
        bit    done;
        resp_t r;
        wb_t   w;
        memRead_in = rd; memWrite_in = wr; memToReg_in = m2r; wen_in = wen;
        jal_in = jal; w_addr_in = wa; w_data_in = wd; Rdata2_in = rd2; PC_in = pc;
        memop = rd | wr;
        if (memop) begin
            r.noack = noack; r.n = n; r.rdata = rdata;
            r.we = wr; r.addr = wd[7:0]; r.wdata = rd2;
            resp_q.push_back(r);
            if (!noack && !wr && wen) begin
                w.a = wa; w.d = m2r ? rdata : wd;
                wb_q.push_back(w);
            end
            exp_stall = noack ? MAX_WAIT : 1 + n;
        end else begin
            if (wen) begin
                w.a = wa; w.d = jal ? pc : wd;
                wb_q.push_back(w);
            end
            exp_stall = 0;
        end
        cnt = 0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (c == 0) check("mem_err_sticky", 32'(mem_err), 32'(exp_err));
            if (stall) cnt++;
            else done = 1'b1;
            @(posedge clk);
        end
        check("stall_released", 32'(done), 32'd1);
        check("stall_cycles", 32'(cnt), 32'(exp_stall));
        if (memop && noack) exp_err = 1'b1;
        #1;
    endtask

    task automatic set_nop();
        memRead_in = 0; memWrite_in = 0; memToReg_in = 0; wen_in = 0; jal_in = 0;
        w_addr_in = 0; w_data_in = 0; Rdata2_in = 0; PC_in = 0;
    endtask

    // Memory responder: verifies each new request and acks after the
    // requested number of wait cycles (or never).
    initial begin : responder
        resp_t cur;
        bit    active;
        int    cnt;
        cur.noack = 1'b1; cur.n = 0; cur.rdata = 0; cur.we = 0; cur.addr = 0; cur.wdata = 0;
        active = 1'b0; cnt = 0;
        mem_ack = 1'b0; mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            mem_rdata = 16'($urandom);
            if (mem_req && !rst) begin
                if (!active) begin
                    active = 1'b1;
                    cnt = 0;
                    checks++;
                    if (resp_q.size() == 0) begin
                        errors++;
                        $display("FAIL req_expected actual=unexpected_request required=none at %0t", $time);
                        cur.noack = 1'b1;
                    end else begin
                        cur = resp_q.pop_front();
                        check("mem_we", 32'(mem_we), 32'(cur.we));
                        check("mem_addr", 32'(mem_addr), 32'(cur.addr));
                        if (cur.we) check("mem_wdata", 32'(mem_wdata), 32'(cur.wdata));
                    end
                end
                if (!cur.noack && cnt == cur.n) begin
                    mem_ack = 1'b1;
                    mem_rdata = cur.rdata;
                    active = 1'b0;
                end
                cnt++;
            end else begin
                active = 1'b0;
            end
        end
    end

    // Write-back monitor: every cycle with wb_wen high is one retired write.
    always @(negedge clk) begin
        if (wb_wen) begin
            checks++;
            if (wb_q.size() == 0) begin
                errors++;
                $display("FAIL wb_expected actual=addr %0h data %0h required=no_writeback at %0t",
                         wb_addr, wb_data, $time);
            end else begin
                wb_t e;
                e = wb_q.pop_front();
                if (wb_addr !== e.a || wb_data !== e.d) begin
                    errors++;
                    $display("FAIL wb_value actual=addr %0h data %0h required=addr %0h data %0h at %0t",
                             wb_addr, wb_data, e.a, e.d, $time);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin : driver
        int           kind;
        int           n;
        bit           noack;
        logic         rd, wr, m2r, wen, jal;
        logic [15:0]  wd, rd2, pc, rdata;
        logic [3:0]   wa;

        rst = 1'b1;
        set_nop();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wdata", 32'(mem_wdata), 0);
        check("rst_wb_addr", 32'(wb_addr), 0);
        check("rst_wb_data", 32'(wb_data), 0);
        check("rst_wb_wen", 32'(wb_wen), 0);
        check("rst_mem_err", 32'(mem_err), 0);
        check("rst_stall", 32'(stall), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed cases
        issue(0, 0, 0, 1, 0, 4'd3,  16'h1234, 16'h0,    16'h0,    0, 0, 16'h0);     // ALU op
        issue(1, 0, 1, 1, 0, 4'd7,  16'h0010, 16'h0,    16'h0,    2, 0, 16'hBEEF);  // load, 2 waits
        issue(0, 1, 0, 1, 0, 4'd9,  16'h0020, 16'h00AA, 16'h0,    0, 0, 16'h0);     // store, ack first cycle
        issue(0, 0, 0, 1, 1, 4'd15, 16'h5555, 16'h0,    16'h0042, 0, 0, 16'h0);     // jal link
        issue(1, 0, 1, 1, 0, 4'd2,  16'h0031, 16'h0,    16'h0,    MAX_WAIT-1, 0, 16'h1357); // ack on last cycle
        issue(1, 0, 0, 1, 0, 4'd4,  16'h00A5, 16'h0,    16'h0,    0, 0, 16'h0);     // load, memToReg=0
        issue(1, 1, 1, 1, 0, 4'd6,  16'h0077, 16'h0F0F, 16'h0,    1, 0, 16'h2222);  // both set -> store
        issue(1, 0, 1, 1, 0, 4'd5,  16'h0040, 16'h0,    16'h0,    0, 1, 16'h0);     // never acked
        issue(0, 0, 0, 1, 0, 4'd1,  16'hCAFE, 16'h0,    16'h0,    0, 0, 16'h0);     // proceeds after abort

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 15);
            wa = 4'($urandom); wd = 16'($urandom); rd2 = 16'($urandom);
            pc = 16'($urandom); rdata = 16'($urandom);
            wen = 1'($urandom); m2r = 1'($urandom);
            n = $urandom_range(0, 4);
            if ($urandom_range(0, 7) == 0) n = $urandom_range(0, MAX_WAIT-1);
            noack = 1'b0; rd = 0; wr = 0; jal = 0;
            if (kind < 6) begin
                jal = (kind < 2);
            end else if (kind < 10) begin
                rd = 1;
            end else if (kind < 13) begin
                wr = 1; rd = (kind == 12);
            end else if (kind == 13) begin
                rd = 1'($urandom); wr = ~rd; noack = 1'b1;
            end
            issue(rd, wr, m2r, wen, jal, wa, wd, rd2, pc, n, noack, rdata);
        end

        // Reset during the third BUSY cycle of an unacknowledged load
        check("err_before_rst", 32'(mem_err), 1);
        issue(1, 0, 1, 1, 0, 4'd5, 16'h0033, 16'h0, 16'h0, 0, 1, 16'h0);
        // the issue above aborts; start another never-acked load and reset it
        memRead_in = 1; memWrite_in = 0; memToReg_in = 1; wen_in = 1; jal_in = 0;
        w_addr_in = 4'd8; w_data_in = 16'h0044; Rdata2_in = 0; PC_in = 0;
        begin
            resp_t r;
            r.noack = 1'b1; r.n = 0; r.rdata = 0; r.we = 0; r.addr = 8'h44; r.wdata = 0;
            resp_q.push_back(r);
        end
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        check("busy3_mem_req", 32'(mem_req), 1);
        check("busy3_stall", 32'(stall), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        set_nop();
        exp_err = 1'b0;
        @(negedge clk);
        check("midrst_mem_req", 32'(mem_req), 0);
        check("midrst_wb_wen", 32'(wb_wen), 0);
        check("midrst_mem_err", 32'(mem_err), 0);
        check("midrst_stall", 32'(stall), 0);
        @(posedge clk); #1;
        issue(0, 0, 0, 1, 0, 4'd12, 16'h0BAD, 16'h0, 16'h0, 0, 0, 16'h0);

        set_nop();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("wb_queue_drained", 32'(wb_q.size()), 0);
        check("req_queue_drained", 32'(resp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
